bcd_6d_to_binary_20b: RTL
=========================

Name: bcd_6d_to_binary_20b

Overview:
Sequential BCD-to-binary converter, the decode direction of the display path's binary-to-BCD stage.
- Input: a packed 6-digit BCD word (digit 0 in bits [3:0]), e.g. from key-entry logic that builds a decimal bound for the prime search.
- Output: the equivalent 20-bit binary value for the sieve/search core.
- Method: reverse double-dabble, one shift-and-correct iteration per clock, with a start/done handshake and illegal-digit detection.

Parameters:
NDIG, 6, number of BCD digits in the input word
NBIN, 20, binary result width; must satisfy 2^NBIN > 10^NDIG - 1 (for 6 digits: 999999 < 1048576)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE
bcd_i  input  4*NDIG  packed BCD operand, digit k at bits [4k+3:4k]; sampled on the accepted start cycle only
busy  output  1  high from the cycle after start is accepted until done, inclusive
done  output  1  single-cycle pulse: result (or error) valid
bin_o  output  NBIN  binary result, held stable from done until the next done
err  output  1  high with done if any input digit > 9, held with bin_o

Behaviour:
- One clock (clk), synchronous active-high reset (rst). No asynchronous paths.
- Reset: state=IDLE, busy=0, done=0, bin_o=0, err=0, iteration counter=0, shift register cleared.
- Shift register: {bcd_part[4*NDIG-1:0], bin_part[NBIN-1:0]}. The iteration counter is wide enough for NBIN.
- FSM states: IDLE, CHECK, SHIFT, FINISH.
- IDLE: busy=0. If start=1: load bcd_part<=bcd_i, bin_part<=0, counter<=0, go to CHECK. Otherwise stay.
- CHECK (1 cycle): busy=1. Test every digit of bcd_part for a value > 9.
  - Any illegal digit: set err_pending, go to FINISH.
  - Otherwise: go to SHIFT.
- SHIFT (exactly NBIN cycles): busy=1. Each cycle:
  - Logically shift the whole register right by 1; bcd_part LSB enters bin_part MSB and 0 enters bcd_part MSB.
  - Then, on the shifted value, subtract 3 from each 4-bit BCD digit that is >= 8.
  - Both steps complete in the same cycle and the corrected value is registered.
  - Increment the counter. After the NBIN-th iteration, go to FINISH.
- FINISH (1 cycle): busy=1, done=1.
  - Normal case: bin_o<=bin_part, err<=0.
  - err_pending case: bin_o<=0, err<=1.
  - Next state is IDLE.
- Latency, with start accepted at cycle 0:
  - Legal input: done=1 at cycle NBIN+2 (22 cycles for defaults).
  - Illegal input: done=1 at cycle 2.
  - bin_o/err update on the same edge that raises done.
- After a legal conversion bcd_part must be all zero; this is an internal assertion only and produces no output.
- Simultaneous or early events:
  - start while busy (CHECK/SHIFT/FINISH) is ignored with no effect.
  - start on the done cycle is ignored; the next start is accepted once back in IDLE (earliest the cycle after done).
  - bcd_i changes after acceptance have no effect.
- Reset mid-operation: on the next edge return to IDLE with all outputs at reset values. The previous bin_o is lost and no done is produced.
- Idle hold: bin_o/err keep their last done values indefinitely while IDLE.
- No overflow path exists given the NBIN constraint; the design does not require handling it.

Test Plan:
- Reset, then start with bcd_i=24'h999999 -> busy high cycles 1..22; done pulse at cycle 22; bin_o=20'hF423F (999999); err=0.
- bcd_i=24'h000000 -> done at cycle 22; bin_o=0; err=0. Then bcd_i=24'h123456 -> bin_o=20'h1E240; err=0.
- bcd_i=24'h12A456 (digit 3 = A) -> done at cycle 2; err=1; bin_o=0. A following legal 24'h000002 -> bin_o=2; err cleared to 0.
- Start 24'h000007, then pulse start with 24'h555555 at cycles 5 and 22 (done cycle) -> only one done pulse; bin_o=7; the next start accepted at cycle 23 yields 20'h87A23 (555555) at cycle 45.
- Start 24'h654321, assert rst at cycle 10 for 1 cycle -> busy=0, done never pulses, bin_o=0. A fresh start with 24'h000100 -> bin_o=100 after 22 cycles.
- Sweep all 0..999999 (or random 10k values), back-to-back starts issued the cycle after each done -> bin_o equals the decimal value every time; err=0; the done-to-done spacing is exactly 23 cycles.

Source files
------------

// File: rtl/bcd_6d_to_binary_20b_if.sv
// Start/done handshake bundle between the BCD key-entry side and the BCD-to-binary converter.
// The master issues start with a packed BCD operand; the slave answers with busy, done, result and error.
interface bcd_6d_to_binary_20b_if #(
    parameter int NDIG = 6,
    parameter int NBIN = 20
);
    logic                start;
    logic [4*NDIG-1:0]   bcd_i;
    logic                busy;
    logic                done;
    logic [NBIN-1:0]     bin_o;
    logic                err;

    modport master (
        output start, bcd_i,
        input  busy, done, bin_o, err
    );

    modport slave (
        input  start, bcd_i,
        output busy, done, bin_o, err
    );
endinterface

// File: rtl/bcd_6d_to_binary_20b.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift-and-correct step per clock.
// Illegal digits (> 9) are caught before shifting and reported through err with a zero result.
module bcd_6d_to_binary_20b #(
    parameter int NDIG = 6,
    parameter int NBIN = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_6d_to_binary_20b_if.slave bus
);
    localparam int W  = 4*NDIG + NBIN;
    localparam int CW = $clog2(NBIN + 1);

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, FINISH} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_pend_q, err_pend_d;
    logic            done_q, done_d;
    logic [NBIN-1:0] bin_q, bin_d;
    logic            err_q, err_d;

    logic            illegal;
    logic [W-1:0]    shifted;

    // Digit legality test and the shift-then-correct step on the BCD half of the register.
    always_comb begin
        illegal = 1'b0;
        shifted = {1'b0, sreg_q[W-1:1]};
        for (int k = 0; k < NDIG; k++) begin
            if (sreg_q[NBIN+4*k +: 4] > 4'd9) begin
                illegal = 1'b1;
            end
            if (shifted[NBIN+4*k +: 4] >= 4'd8) begin
                shifted[NBIN+4*k +: 4] = shifted[NBIN+4*k +: 4] - 4'd3;
            end
        end
    end

    // Result registers load on the edge into FINISH, so done, bin_o and err all change together.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        done_d     = 1'b0;
        bin_d      = bin_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sreg_d     = {bus.bcd_i, {NBIN{1'b0}}};
                    cnt_d      = '0;
                    err_pend_d = 1'b0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (illegal) begin
                    err_pend_d = 1'b1;
                    done_d     = 1'b1;
                    bin_d      = '0;
                    err_d      = 1'b1;
                    state_d    = FINISH;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = shifted;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(NBIN - 1)) begin
                    done_d  = 1'b1;
                    bin_d   = shifted[NBIN-1:0];
                    err_d   = 1'b0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            done_q     <= 1'b0;
            bin_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            done_q     <= done_d;
            bin_q      <= bin_d;
            err_q      <= err_d;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.bin_o = bin_q;
    assign bus.err   = err_q;

    // A legal conversion must have drained every BCD digit into the binary half.
    bcd_drained_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == FINISH && !err_pend_q) |-> (sreg_q[W-1:NBIN] == '0));

endmodule
